// File: rtl/window_gen4x4.sv
// Streaming 4x4 sliding-window generator: three line buffers plus a 4x4 shift
// register, emitting every stride-1 window of a raster-order frame.
module window_gen4x4 #(
  parameter int lenOfInput = 8,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [lenOfInput-1:0]      in_pixel,
  input  logic                       in_sof,
  output logic                       win_valid,
  input  logic                       out_ready,
  output logic [16*lenOfInput-1:0]   win_data,
  output logic [15:0]                win_row,
  output logic [15:0]                win_col,
  output logic                       win_eof
);

  localparam int          XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [15:0] X_LAST = 16'(IMG_W - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_H - 1);

  logic [15:0]           x, y;
  logic [15:0]           x_cur, y_cur;
  logic [XW-1:0]         xi;
  logic                  acc;
  logic                  emit;
  logic [lenOfInput-1:0] lb0 [IMG_W];
  logic [lenOfInput-1:0] lb1 [IMG_W];
  logic [lenOfInput-1:0] lb2 [IMG_W];
  logic [lenOfInput-1:0] win [4][4];

  assign in_ready = ~win_valid | out_ready;
  assign acc      = in_valid & in_ready;

  // sof forces the accepted pixel to (0,0) before any use of the position
  assign x_cur = in_sof ? 16'd0 : x;
  assign y_cur = in_sof ? 16'd0 : y;
  assign xi    = x_cur[XW-1:0];
  assign emit  = (y_cur >= 16'd3) && (x_cur >= 16'd3);

  always_comb begin
    win_data = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        win_data[(r*4+c)*lenOfInput +: lenOfInput] = win[r][c];
  end

  // Line buffers carry no reset; stale rows never reach an emitted window.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb2[xi] <= lb1[xi];
      lb1[xi] <= lb0[xi];
      lb0[xi] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      win_valid <= 1'b0;
      win_eof   <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          win[r][c] <= '0;
    end else begin
      if (acc) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 3; c++)
            win[r][c] <= win[r][c+1];
        win[0][3] <= lb2[xi];
        win[1][3] <= lb1[xi];
        win[2][3] <= lb0[xi];
        win[3][3] <= in_pixel;

        if (x_cur == X_LAST) begin
          x <= '0;
          y <= (y_cur == Y_LAST) ? 16'd0 : y_cur + 16'd1;
        end else begin
          x <= x_cur + 16'd1;
          y <= y_cur;
        end
      end

      if (acc && emit) begin
        win_valid <= 1'b1;
        win_row   <= y_cur - 16'd3;
        win_col   <= x_cur - 16'd3;
        win_eof   <= (y_cur == Y_LAST) && (x_cur == X_LAST);
      end else if (out_ready) begin
        win_valid <= 1'b0;
        win_eof   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_gen4x4.sv
// Bench for window_gen4x4 on an 8x8 frame: a pixel-image model pushes expected
// windows into a queue on acceptance; they are popped on each output handshake.
module tb_window_gen4x4;
  localparam int L = 8;
  localparam int W = 8;
  localparam int H = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_sof = 1'b0;
  logic             out_ready = 1'b1;
  logic [L-1:0]     in_pixel = '0;
  logic             in_ready, win_valid, win_eof;
  logic [16*L-1:0]  win_data;
  logic [15:0]      win_row, win_col;

  typedef struct {
    logic [16*L-1:0] data;
    logic [15:0]     row;
    logic [15:0]     col;
    logic            eof;
  } win_t;

  win_t          q[$];
  logic [L-1:0]  img [H][W];
  int            bx, by;
  int            errors, checks;
  int            n_win, n_eof;
  int            or_mode, cyc;

  window_gen4x4 #(.lenOfInput(L), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_sof(in_sof), .win_valid(win_valid),
    .out_ready(out_ready), .win_data(win_data), .win_row(win_row),
    .win_col(win_col), .win_eof(win_eof)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic sof, input logic [L-1:0] pix);
    win_t w;
    logic [16*L-1:0] d;
    if (sof) begin bx = 0; by = 0; end
    img[by][bx] = pix;
    if (by >= 3 && bx >= 3) begin
      d = '0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          d[(r*4+c)*L +: L] = img[by-3+r][bx-3+c];
      w.data = d;
      w.row  = 16'(by - 3);
      w.col  = 16'(bx - 3);
      w.eof  = (by == H-1) && (bx == W-1);
      q.push_back(w);
    end
    if (bx == W-1) begin
      bx = 0;
      by = (by == H-1) ? 0 : by + 1;
    end else bx++;
  endtask

  function automatic logic ready_now();
    if (or_mode == 0) return 1'b1;
    return (cyc % 4 == 0) || (cyc % 4 == 3);
  endfunction

  // One cycle: drive at negedge, check outputs against the scoreboard head.
  task automatic step(input logic v, input logic sof, input logic [L-1:0] pix, output logic accepted);
    logic ordy, exp_rdy;
    @(negedge clk);
    ordy = ready_now();
    cyc++;
    in_valid = v; in_sof = sof; in_pixel = pix; out_ready = ordy;
    #1;
    exp_rdy = (q.size() == 0) || ordy;
    chk("win_valid", 128'(win_valid), 128'(q.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    if (q.size() > 0) begin
      chk("win_data", 128'(win_data), 128'(q[0].data));
      chk("win_row", 128'(win_row), 128'(q[0].row));
      chk("win_col", 128'(win_col), 128'(q[0].col));
      chk("win_eof", 128'(win_eof), 128'(q[0].eof));
      if (ordy) begin
        n_win++;
        if (q[0].eof) n_eof++;
        void'(q.pop_front());
      end
    end
    accepted = v && exp_rdy;
    if (accepted) model_accept(sof, pix);
  endtask

  task automatic send(input logic [L-1:0] pix, input logic sof);
    logic a;
    int guard;
    a = 1'b0;
    guard = 0;
    while (!a) begin
      step(1'b1, sof, pix, a);
      guard++;
      if (!a && guard > 20) begin
        chk("accept_timeout", 128'(guard), 128'(0));
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, a);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 20) begin idle(1); guard++; end
    chk("drain_empty", 128'(q.size()), 128'(0));
    idle(1);
  endtask

  task automatic ramp_frame(input logic first_sof);
    for (int i = 0; i < W*H; i++) send(L'(i), (i == 0) ? first_sof : 1'b0);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_windows"}, 128'(n_win), 128'((H-3)*(W-3)));
    chk({tag, "_eofs"}, 128'(n_eof), 128'(1));
    n_win = 0;
    n_eof = 0;
  endtask

  initial begin
    errors = 0; checks = 0; n_win = 0; n_eof = 0;
    or_mode = 0; cyc = 0; bx = 0; by = 0;

    // Reset state
    #3;
    chk("rst_win_valid", 128'(win_valid), 128'(0));
    chk("rst_win_eof", 128'(win_eof), 128'(0));
    chk("rst_win_row", 128'(win_row), 128'(0));
    chk("rst_win_col", 128'(win_col), 128'(0));
    chk("rst_win_data", 128'(win_data), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // Free-running ramp, with explicit first-window spot checks
    for (int i = 0; i < 28; i++) send(L'(i), i == 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("first_valid", 128'(win_valid), 128'(1));
    chk("first_d00", 128'(win_data[0*L +: L]), 128'(0));
    chk("first_d03", 128'(win_data[3*L +: L]), 128'(3));
    chk("first_d30", 128'(win_data[12*L +: L]), 128'(24));
    chk("first_d33", 128'(win_data[15*L +: L]), 128'(27));
    chk("first_row", 128'(win_row), 128'(0));
    chk("first_col", 128'(win_col), 128'(0));
    for (int i = 28; i < W*H; i++) send(L'(i), 1'b0);
    drain();
    check_counts("free");

    // Same ramp with out_ready toggled 1-0-0-1
    or_mode = 1; cyc = 0;
    ramp_frame(1'b1);
    drain();
    check_counts("toggle");
    or_mode = 0;

    // Signed pass-through
    for (int i = 0; i < W*H; i++) send(8'h80, i == 0);
    drain();
    check_counts("neg");

    // Mid-frame sof after 20 pixels of a different frame
    for (int i = 0; i < 20; i++) send(L'(100 + i), i == 0);
    ramp_frame(1'b1);
    drain();
    check_counts("midsof");

    // Idle gaps: 3 idle cycles after every 5 pixels
    for (int i = 0; i < W*H; i++) begin
      send(L'(i), i == 0);
      if (i % 5 == 4) idle(3);
    end
    drain();
    check_counts("gaps");

    // Asynchronous reset during row 5
    for (int i = 0; i < 46; i++) send(L'(i), i == 0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    chk("prereset_valid", 128'(win_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("async_valid", 128'(win_valid), 128'(0));
    chk("async_row", 128'(win_row), 128'(0));
    chk("async_data", 128'(win_data), 128'(0));
    chk("async_in_ready", 128'(in_ready), 128'(1));
    q.delete();
    bx = 0; by = 0; n_win = 0; n_eof = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ramp_frame(1'b0);
    drain();
    check_counts("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/window_gen4x4.md
# window_gen4x4

Streaming 4x4 sliding-window generator that sits directly upstream of the 4x4 convolution stage. It accepts a raster-order pixel stream, buffers three previous image rows, and presents every stride-1 4x4 window as sixteen signed pixels on a registered valid/ready output. The output feeds the convolution data inputs `data00`..`data33` unchanged.

## Interface
- `lenOfInput`, 8, pixel width in bits (signed two's complement)
- `IMG_W`, 32, image width in pixels (>= 4)
- `IMG_H`, 32, image height in pixels (>= 4)

- `clk` input 1: single clock; everything is rising-edge
- `rst_n` input 1: asynchronous, active-low reset
- `in_valid` input 1: pixel present on `in_pixel`
- `in_ready` output 1: block can accept a pixel
- `in_pixel` input lenOfInput: signed pixel, raster order (row-major, left to right)
- `in_sof` input 1: qualified by `in_valid`; marks the pixel as (row 0, col 0)
- `win_valid` output 1: window present on `win_data`
- `out_ready` input 1: downstream accepts the window
- `win_data` output 16*lenOfInput: slice `[(r*4+c)*lenOfInput +: lenOfInput]` = `data{r}{c}`. r=0 is the top (oldest) row. c=0 is the leftmost column.
- `win_row` output 16: top-left row of the window
- `win_col` output 16: top-left column of the window
- `win_eof` output 1: valid with the last window of a frame

## Operation
- Accept: `acc = in_valid & in_ready`. `in_ready = ~win_valid | out_ready` (combinational).
- Position counters `x`, `y`:
  - reset to 0,0.
  - On `acc`, the pixel is at (y,x), or at (0,0) if `in_sof`.
  - After acceptance, x increments. At x=IMG_W-1, x wraps to 0 and y increments. At (IMG_H-1, IMG_W-1), both wrap to 0.
- Line buffers:
  - `lb0`, `lb1`, `lb2` are each IMG_W deep and hold rows y-1, y-2, y-3 respectively.
  - On `acc` at column x: `lb2[x]<=lb1[x]`, `lb1[x]<=lb0[x]`, `lb0[x]<=pixel`.
  - Contents are not reset.
- Window register (4x4):
  - On `acc`, columns 0..2 take columns 1..3.
  - Column 3 takes {lb2[x], lb1[x], lb0[x], pixel} for rows 0..3.
  - The window register drives `win_data` directly.
  - It shifts on every `acc`, including when no window is emitted.
- Emission:
  - On `acc` with y>=3 and x>=3 (after the sof override), `win_valid` is set at that edge.
  - `win_row=y-3`, `win_col=x-3`.
  - `win_eof=1` if (y,x)=(IMG_H-1, IMG_W-1).
- Clearing: on `win_valid & out_ready` with no new emission, `win_valid` and `win_eof` clear.
- Back-to-back: a new emitting `acc` in the same cycle as a handshake keeps `win_valid` high and loads the next window.
- Stall: while `win_valid & ~out_ready`:
  - `in_ready=0`.
  - `win_data`, `win_row`, `win_col`, `win_eof` hold stable.
- Windows per frame: (IMG_H-3)*(IMG_W-3). No windows straddle a row boundary, because x<3 suppresses emission.
- Mid-frame `in_sof`:
  - Counters restart.
  - Stale line-buffer data is never emitted, because the first window needs rows 0..3 of the new frame.
- Pixel arithmetic: none. Pixels pass bit-exact, including negative values.

## Timing
- Reset values:
  - `win_valid=0`, `win_eof=0`, `win_row=0`, `win_col=0`, `win_data=0`, x=y=0.
  - `in_ready=1` once `rst_n` is high.
- Latency: a window is valid on the cycle after the edge that accepts its bottom-right pixel (1 cycle).
- Throughput: 1 pixel/cycle and 1 window/cycle when `out_ready` is held high.
- Reset mid-frame (asynchronous):
  - Outputs and counters clear immediately.
  - The next accepted pixel is (0,0), regardless of `in_sof`.
- `in_valid` gaps: no state changes; outputs are held.
- `in_sof` without `in_valid`: ignored.

## Test plan
- IMG_W=IMG_H=8, ramp pixel=y*8+x, `out_ready=1`:
  - first `win_valid` one cycle after the 28th accepted pixel, with data00=0, data03=3, data30=24, data33=27, row=0, col=0.
  - 25 windows total; `win_eof` on the window with row=4, col=4 and data33=63.
- Same ramp with `out_ready` toggled 1-0-0-1 throughout:
  - `in_ready` drops during each stall and window contents hold.
  - Window sequence is identical to the free-running run.
- Signed pass-through: constant pixel -128 (8'h80) gives all sixteen slices = 8'h80.
- Mid-frame sof: after 20 pixels of a frame, an `in_sof` pixel is sent, followed by an 8x8 ramp:
  - exactly 25 windows result, all matching the clean-frame values.
- Mid-frame reset: assert `rst_n=0` asynchronously during row 5:
  - `win_valid` drops in the same cycle.
  - After release, a fresh frame yields the correct first window.
- Idle gaps: `in_valid` deasserted for 3 cycles every 5 pixels:
  - window values, coordinates and count are unchanged.
